address_multiply_scheduler: RTL and testbench
=============================================

ADDRESS_MULTIPLY_SCHEDULER -- requirements
Module: address_multiply_scheduler

Interface
REQ-001 SHALL have parameter LATENCY, default 7: clk edges from presenting read addresses/operands to a valid multiplier product.
REQ-002 SHALL have parameter NREG, default 8: number of A registers; index width is clog2(NREG) = 3.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port i_issue_valid, input, 1: an instruction is offered this cycle.
REQ-006 SHALL have port o_issue_ready, output, 1: scheduler accepts the offered instruction this cycle.
REQ-007 SHALL have port i_opcode, input, 7: instruction opcode; legal values are 7'o22 and 7'o23.
REQ-008 SHALL have ports i_ai, i_aj, i_ak, input, 3 each: destination, first source and second source A-register indices.
REQ-009 SHALL have port i_ext_busy, input, NREG: A registers reserved by other functional units.
REQ-010 SHALL have ports o_rd_j and o_rd_k, output, 3 each: register-file read addresses feeding the multiplier operands.
REQ-011 SHALL have port o_rd_en, output, 1: the read addresses are valid, meaning an operation is issued this cycle.
REQ-012 SHALL have port i_product, input, 32: the low 32 bits of the multiplier result.
REQ-013 SHALL have ports o_wb_en (output, 1), o_wb_addr (output, 3) and o_wb_data (output, 32): A-register writeback.
REQ-014 SHALL have port o_a_busy, output, NREG: reservations held by this unit.
REQ-015 SHALL have port o_illegal, output, 1: one-cycle pulse when an offered opcode is illegal.
REQ-016 SHALL have port o_outstanding, output, clog2(LATENCY+1): count of in-flight operations.

Function
REQ-017 SHALL compute, when the opcode is legal, hazard = o_a_busy[i]|o_a_busy[j]|o_a_busy[k]|i_ext_busy[i]|i_ext_busy[j]|i_ext_busy[k].
REQ-018 SHALL drive o_issue_ready = !hazard for a legal opcode and 1 for an illegal opcode, combinationally.
REQ-019 SHALL perform an issue when valid&ready&legal: o_rd_en=1, o_rd_j=i_aj, o_rd_k=i_ak in the same cycle, set o_a_busy[i_ai] at the edge, and enter tag {1,i_ai} into stage 0 of the tag pipeline.
REQ-020 SHALL, when valid&ready&illegal, pulse o_illegal for that cycle only, issue nothing and change no state.
REQ-021 SHALL shift the tag pipeline by one stage every cycle without stalling; the multiplier pipeline is never stalled.
REQ-022 SHALL, when a valid tag reaches stage LATENCY-1 (LATENCY cycles after issue), assert o_wb_en=1, o_wb_addr=tag index and o_wb_data=i_product, all combinational in that cycle.
REQ-023 SHALL clear o_a_busy[tag index] at the edge ending the writeback cycle; a waiting instruction that uses that register issues the following cycle, with no bypass.
REQ-024 SHALL stall an instruction that needs a register being written back in the current cycle, because its busy bit is still set.
REQ-025 SHALL allow an issue and a writeback in the same cycle; o_outstanding is then unchanged.
REQ-026 SHALL stall an instruction with i==j, i==k or j==k only on the rules above; a self-referencing operation is legal.
REQ-027 SHALL accept back-to-back independent issues at 1 per cycle, so up to LATENCY operations are in flight.
REQ-028 SHALL treat opcodes 022 and 023 identically.

Reset
REQ-029 SHALL on rst_n low, asynchronously, clear all tag valids and o_a_busy, set o_outstanding=0, and drive o_wb_en=0, o_rd_en=0 and o_illegal=0.
REQ-030 SHALL discard in-flight operations on a reset mid-operation, with no writeback after release.
REQ-031 SHALL accept an issue on the first rising edge after rst_n deasserts.

Structure
REQ-032 SHALL place in shared package cray2_amu_pkg: the opcode constants OP_AMUL0=7'o22 and OP_AMUL1=7'o23, the A-register index width, and the default LATENCY.
REQ-033 SHALL contain exactly one sub-module, amu_tag_pipe: a LATENCY-deep shift register of {valid, index} with async active-low clear.

Verification
REQ-034 SHALL cover single issue: 022, i=3, j=1, k=2, product stub returns 0x0000_0006 -> o_rd_en at cycle 0, o_wb_en/addr=3/data=6 at cycle 7, o_a_busy[3] set for cycles 1..7 and clear at cycle 8.
REQ-035 SHALL cover RAW hazard: issue i=3 at cycle 0, then offer j=3 at cycle 1 -> ready=0 for cycles 1..7, issue at cycle 8.
REQ-036 SHALL cover throughput: 7 independent issues on cycles 0..6 (i=0..6) -> o_outstanding=7 at cycle 7, writebacks on cycles 7..13 in order, no stall.
REQ-037 SHALL cover an illegal opcode: 7'o24 offered -> ready=1, o_illegal pulses for 1 cycle, busy unchanged, no writeback.
REQ-038 SHALL cover an external hazard: i_ext_busy=8'h04 with k=2 -> ready=0 until i_ext_busy clears, then issue in that same cycle.
REQ-039 SHALL cover reset mid-flight: 3 operations in flight, rst_n low for 2 cycles -> busy=0, o_outstanding=0, no o_wb_en ever asserted afterward.

Source files
------------

// File: rtl/cray2_amu_pkg.sv
// Shared constants and types for the A-register multiply scheduler.
package cray2_amu_pkg;

  localparam logic [6:0] OP_AMUL0 = 7'o22;
  localparam logic [6:0] OP_AMUL1 = 7'o23;

  localparam int unsigned AIDX_W          = 3;
  localparam int unsigned DEFAULT_LATENCY = 7;

  typedef struct packed {
    logic              valid;
    logic [AIDX_W-1:0] idx;
  } amu_tag_t;

  function automatic logic is_amul(input logic [6:0] op);
    return (op == OP_AMUL0) || (op == OP_AMUL1);
  endfunction

endpackage

// File: rtl/amu_tag_pipe.sv
// Fixed-depth shift register of destination tags that tracks in-flight multiplies.
module amu_tag_pipe
  import cray2_amu_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_LATENCY
) (
  input  logic     clk,
  input  logic     rst_n,
  input  amu_tag_t in_tag,
  output amu_tag_t out_tag
);

  amu_tag_t stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < DEPTH; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0] <= in_tag;
      for (int s = 1; s < DEPTH; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign out_tag = stage_q[DEPTH-1];

endmodule

// File: rtl/address_multiply_scheduler.sv
// Issue/hazard control for the A-register multiplier: reserves destinations, tracks
// in-flight operations and writes the product back after a fixed latency.
module address_multiply_scheduler
  import cray2_amu_pkg::*;
#(
  parameter int unsigned LATENCY = DEFAULT_LATENCY,
  parameter int unsigned NREG    = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_issue_valid,
  output logic                               o_issue_ready,
  input  logic [6:0]                         i_opcode,
  input  logic [AIDX_W-1:0]                  i_ai,
  input  logic [AIDX_W-1:0]                  i_aj,
  input  logic [AIDX_W-1:0]                  i_ak,
  input  logic [NREG-1:0]                    i_ext_busy,
  output logic [AIDX_W-1:0]                  o_rd_j,
  output logic [AIDX_W-1:0]                  o_rd_k,
  output logic                               o_rd_en,
  input  logic [31:0]                        i_product,
  output logic                               o_wb_en,
  output logic [AIDX_W-1:0]                  o_wb_addr,
  output logic [31:0]                        o_wb_data,
  output logic [NREG-1:0]                    o_a_busy,
  output logic                               o_illegal,
  output logic [$clog2(LATENCY+1)-1:0]       o_outstanding
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  logic             legal;
  logic             hazard;
  logic             fire;
  logic             wb;
  logic [NREG-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  amu_tag_t         issue_tag;
  amu_tag_t         wb_tag;

  assign legal  = is_amul(i_opcode);
  // WAW on the destination counts as a hazard too, so each register has at most one owner.
  assign hazard = busy_q[i_ai] | busy_q[i_aj] | busy_q[i_ak] |
                  i_ext_busy[i_ai] | i_ext_busy[i_aj] | i_ext_busy[i_ak];

  assign o_issue_ready = legal ? !hazard : 1'b1;

  // Gated by rst_n so nothing is issued or flagged while reset is held.
  assign fire      = rst_n & i_issue_valid & legal & !hazard;
  assign o_illegal = rst_n & i_issue_valid & !legal;

  assign o_rd_en = fire;
  assign o_rd_j  = i_aj;
  assign o_rd_k  = i_ak;

  assign issue_tag = '{valid: fire, idx: i_ai};

  amu_tag_pipe #(
    .DEPTH (LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_tag  (issue_tag),
    .out_tag (wb_tag)
  );

  assign wb        = wb_tag.valid;
  assign o_wb_en   = wb;
  assign o_wb_addr = wb_tag.idx;
  assign o_wb_data = i_product;

  always_comb begin
    busy_d = busy_q;
    if (wb)   busy_d[wb_tag.idx] = 1'b0;
    if (fire) busy_d[i_ai]       = 1'b1;
    cnt_d = cnt_q + CNT_W'(fire) - CNT_W'(wb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_a_busy      = busy_q;
  assign o_outstanding = cnt_q;

endmodule

// File: tb/tb_address_multiply_scheduler.sv
// Self-checking bench: vector table plus directed sequences, writebacks checked by scoreboard.
module tb_address_multiply_scheduler;
  import cray2_amu_pkg::*;

  localparam int LAT = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_issue_valid;
  logic        o_issue_ready;
  logic [6:0]  i_opcode;
  logic [2:0]  i_ai, i_aj, i_ak;
  logic [7:0]  i_ext_busy;
  logic [2:0]  o_rd_j, o_rd_k;
  logic        o_rd_en;
  logic [31:0] i_product;
  logic        o_wb_en;
  logic [2:0]  o_wb_addr;
  logic [31:0] o_wb_data;
  logic [7:0]  o_a_busy;
  logic        o_illegal;
  logic [2:0]  o_outstanding;

  address_multiply_scheduler #(
    .LATENCY (LAT),
    .NREG    (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_issue_valid (i_issue_valid),
    .o_issue_ready (o_issue_ready),
    .i_opcode      (i_opcode),
    .i_ai          (i_ai),
    .i_aj          (i_aj),
    .i_ak          (i_ak),
    .i_ext_busy    (i_ext_busy),
    .o_rd_j        (o_rd_j),
    .o_rd_k        (o_rd_k),
    .o_rd_en       (o_rd_en),
    .i_product     (i_product),
    .o_wb_en       (o_wb_en),
    .o_wb_addr     (o_wb_addr),
    .o_wb_data     (o_wb_data),
    .o_a_busy      (o_a_busy),
    .o_illegal     (o_illegal),
    .o_outstanding (o_outstanding)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier stub: register Aj holds j+1, Ak holds k+1.
  logic [31:0] prod_pipe [LAT];
  always @(posedge clk) begin
    prod_pipe[0] <= o_rd_en ? (32'(o_rd_j) + 32'd1) * (32'(o_rd_k) + 32'd1) : 32'h0;
    for (int s = 1; s < LAT; s++) prod_pipe[s] <= prod_pipe[s-1];
  end
  assign i_product = prod_pipe[LAT-1];

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
    int          due;
  } wb_exp_t;
  wb_exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  always @(negedge clk) begin : wb_monitor
    wb_exp_t e;
    if (o_wb_en !== 1'b0) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", 32'(o_wb_en), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wb_addr", 32'(o_wb_addr), 32'(e.addr));
        chk("wb_data", o_wb_data, e.data);
        chk("wb_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] i, input logic [2:0] j,
                       input logic [2:0] k, input logic [7:0] ext);
    i_issue_valid = v;
    i_opcode      = op;
    i_ai          = i;
    i_aj          = j;
    i_ak          = k;
    i_ext_busy    = ext;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Waits to mid-cycle and checks handshake outputs; a predicted issue is queued for writeback.
  task automatic check_cycle(input string name, input logic rdy, input logic rd, input logic ill);
    @(negedge clk);
    chk({name, "_ready"}, 32'(o_issue_ready), 32'(rdy));
    chk({name, "_rd_en"}, 32'(o_rd_en), 32'(rd));
    chk({name, "_illegal"}, 32'(o_illegal), 32'(ill));
    if (rd) begin
      chk({name, "_rd_j"}, 32'(o_rd_j), 32'(i_aj));
      chk({name, "_rd_k"}, 32'(o_rd_k), 32'(i_ak));
      sb.push_back('{addr: i_ai, data: (32'(i_aj) + 32'd1) * (32'(i_ak) + 32'd1), due: cyc + LAT});
    end
  endtask

  task automatic drain(input string name);
    drive(1'b0, OP_AMUL0, 3'd0, 3'd0, 3'd0, 8'h00);
    for (int c = 0; c < 3 * LAT; c++) begin
      if (sb.size() == 0) break;
      next_cycle();
    end
    chk({name, "_drained"}, 32'(sb.size()), 32'd0);
    chk({name, "_busy_idle"}, 32'(o_a_busy), 32'd0);
    chk({name, "_outst_idle"}, 32'(o_outstanding), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, OP_AMUL0, 3'd0, 3'd0, 3'd0, 8'h00);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       v;
    logic [6:0] op;
    logic [2:0] i, j, k;
    logic [7:0] ext;
    logic       rdy, rd, ill;
  } vec_t;
  vec_t tbl [9];

  initial begin
    tbl[0] = '{1'b1, 7'o22, 3'd3, 3'd1, 3'd2, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 7'o23, 3'd0, 3'd3, 3'd1, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 7'o24, 3'd3, 3'd3, 3'd3, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 7'o22, 3'd4, 3'd4, 3'd4, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 7'o22, 3'd5, 3'd4, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 7'o22, 3'd6, 3'd0, 3'd2, 8'h04, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 7'o23, 3'd6, 3'd0, 3'd2, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 7'o22, 3'd3, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 7'o24, 3'd0, 3'd0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0};

    do_reset();
    @(negedge clk);
    chk("reset_busy", 32'(o_a_busy), 32'd0);
    chk("reset_outst", 32'(o_outstanding), 32'd0);
    chk("reset_wb_en", 32'(o_wb_en), 32'd0);
    next_cycle();

    // Table: consecutive cycles starting from an idle unit.
    do_reset();
    for (int n = 0; n < 9; n++) begin
      drive(tbl[n].v, tbl[n].op, tbl[n].i, tbl[n].j, tbl[n].k, tbl[n].ext);
      check_cycle($sformatf("tbl%0d", n), tbl[n].rdy, tbl[n].rd, tbl[n].ill);
      next_cycle();
    end
    drain("tbl");

    // Single issue then a RAW-dependent op waiting on A3.
    do_reset();
    drive(1'b1, OP_AMUL0, 3'd3, 3'd1, 3'd2, 8'h00);
    check_cycle("single", 1'b1, 1'b1, 1'b0);
    next_cycle();
    for (int c = 1; c <= LAT; c++) begin
      drive(1'b1, OP_AMUL0, 3'd5, 3'd3, 3'd0, 8'h00);
      check_cycle($sformatf("raw_c%0d", c), 1'b0, 1'b0, 1'b0);
      chk($sformatf("busy3_c%0d", c), 32'(o_a_busy[3]), 32'd1);
      if (c == 1) chk("outst_c1", 32'(o_outstanding), 32'd1);
      next_cycle();
    end
    check_cycle("raw_issue", 1'b1, 1'b1, 1'b0);
    chk("busy3_c8", 32'(o_a_busy[3]), 32'd0);
    next_cycle();
    drain("raw");

    // Back-to-back independent issues fill the pipe.
    do_reset();
    for (int n = 0; n < LAT; n++) begin
      drive(1'b1, (n % 2 == 0) ? OP_AMUL0 : OP_AMUL1, 3'(n), 3'd7, 3'd7, 8'h00);
      check_cycle($sformatf("thru%0d", n), 1'b1, 1'b1, 1'b0);
      next_cycle();
    end
    drive(1'b0, OP_AMUL0, 3'd0, 3'd0, 3'd0, 8'h00);
    @(negedge clk);
    chk("thru_outst_full", 32'(o_outstanding), 32'(LAT));
    chk("thru_busy_full", 32'(o_a_busy), 32'h7f);
    next_cycle();
    drain("thru");

    // Illegal opcode while an op is in flight: no state change.
    do_reset();
    drive(1'b1, OP_AMUL1, 3'd2, 3'd0, 3'd0, 8'h00);
    check_cycle("ill_pre", 1'b1, 1'b1, 1'b0);
    next_cycle();
    drive(1'b1, 7'o24, 3'd2, 3'd2, 3'd2, 8'h00);
    check_cycle("ill", 1'b1, 1'b0, 1'b1);
    next_cycle();
    drive(1'b0, 7'o24, 3'd2, 3'd2, 3'd2, 8'h00);
    check_cycle("ill_after", 1'b1, 1'b0, 1'b0);
    chk("ill_busy", 32'(o_a_busy), 32'h04);
    chk("ill_outst", 32'(o_outstanding), 32'd1);
    next_cycle();
    drain("ill");

    // External reservation on Ak stalls until it drops, then issues that cycle.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, OP_AMUL0, 3'd1, 3'd0, 3'd2, 8'h04);
      check_cycle($sformatf("ext_stall%0d", c), 1'b0, 1'b0, 1'b0);
      next_cycle();
    end
    drive(1'b1, OP_AMUL0, 3'd1, 3'd0, 3'd2, 8'h00);
    check_cycle("ext_go", 1'b1, 1'b1, 1'b0);
    next_cycle();
    drain("ext");

    // Reset with three ops in flight; op offered across release issues on first edge.
    do_reset();
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, OP_AMUL0, 3'(n), 3'd7, 3'd7, 8'h00);
      check_cycle($sformatf("mid%0d", n), 1'b1, 1'b1, 1'b0);
      next_cycle();
    end
    rst_n = 1'b0;
    sb.delete();
    drive(1'b1, OP_AMUL0, 3'd4, 3'd5, 3'd6, 8'h00);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("rst_busy%0d", c), 32'(o_a_busy), 32'd0);
      chk($sformatf("rst_outst%0d", c), 32'(o_outstanding), 32'd0);
      chk($sformatf("rst_wb_en%0d", c), 32'(o_wb_en), 32'd0);
      chk($sformatf("rst_rd_en%0d", c), 32'(o_rd_en), 32'd0);
      next_cycle();
    end
    rst_n = 1'b1;
    check_cycle("post_rst", 1'b1, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, OP_AMUL0, 3'd0, 3'd0, 3'd0, 8'h00);
    repeat (2 * LAT) next_cycle();
    drain("mid");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
